// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Desc     : Shared encodings for the IF/DM arbiter in front of the BaseRAM
//            controller: FSM states, source ids, abort data, rw encoding.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_DONE = 2'd2;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_DM = 1'b1;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    // Controller encoding: 1 = read, 0 = write
    typedef enum logic {
        RW_WRITE = 1'b0,
        RW_READ  = 1'b1
    } mem_rw_e;

    function automatic mem_rw_e cmd_rw(input logic src, input logic we);
        if (src == SRC_IF) begin
            return RW_READ;
        end
        return we ? RW_WRITE : RW_READ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_if
// Desc     : CPU IF/DM request ports and BaseRAM controller command bus.
//            slave = arbiter side, master = CPU + controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_arb_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;

    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic [3:0]    dm_be_i;
    logic          dm_gnt_o;
    logic          dm_rvalid_o;
    logic [DW-1:0] dm_rdata_o;

    logic          mem_start_o;
    logic          mem_rw_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_r_ready_i;
    logic          mem_w_finish_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_start_o, mem_rw_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i, mem_r_ready_i, mem_w_finish_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_start_o, mem_rw_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i, mem_r_ready_i, mem_w_finish_i
    );
endinterface
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pick
// Desc     : Combinational 2-way picker producing a one-hot grant.
//            SRAM_ARB_RR_EN defined: collisions go to the source named by
//            i_prio; otherwise DM always beats IF.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  wire logic i_req_if,
    input  wire logic i_req_dm,
`ifdef SRAM_ARB_RR_EN
    input  wire logic i_prio,
`endif
    output logic      o_gnt_if,
    output logic      o_gnt_dm
);

`ifdef SRAM_ARB_RR_EN
    assign o_gnt_dm = i_req_dm & (~i_req_if | (i_prio == SRC_DM));
    assign o_gnt_if = i_req_if & (~i_req_dm | (i_prio == SRC_IF));
`else
    assign o_gnt_dm = i_req_dm;
    assign o_gnt_if = i_req_if & ~i_req_dm;
`endif

endmodule
`default_nettype wire

// File: rtl/sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb
// Desc     : Arbitrates CPU IF and DM ports onto the single-command BaseRAM
//            controller, one transaction in flight. Round-robin on collisions
//            when SRAM_ARB_RR_EN is defined, else fixed DM-over-IF.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int AW          = 24,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    sram_arb_if.slave bus,
    output logic      busy_o,
    output logic      err_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [1:0]    r_state;
    logic          r_src;
    mem_rw_e       r_rw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_be;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic          w_idle;
    logic          w_if_gnt;
    logic          w_dm_gnt;
    logic          w_done_ok;
    logic          w_timeout;
    logic [DW-1:0] w_resp_data;

    // Grants are only offered in IDLE and never while reset is asserted
    assign w_idle = (r_state == ARB_IDLE) & rst_ni;

`ifdef SRAM_ARB_RR_EN
    logic r_prio;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio <= SRC_DM;
        end else if (w_dm_gnt) begin
            r_prio <= SRC_IF;
        end else if (w_if_gnt) begin
            r_prio <= SRC_DM;
        end
    end
`endif

    sram_arb_pick u_pick (
        .i_req_if (bus.if_req_i & w_idle),
        .i_req_dm (bus.dm_req_i & w_idle),
`ifdef SRAM_ARB_RR_EN
        .i_prio   (r_prio),
`endif
        .o_gnt_if (w_if_gnt),
        .o_gnt_dm (w_dm_gnt)
    );

    // Only the completion matching the latched command type counts
    assign w_done_ok   = (r_rw == RW_READ) ? bus.mem_r_ready_i : bus.mem_w_finish_i;
    assign w_resp_data = w_done_ok ? ((r_rw == RW_READ) ? bus.mem_rdata_i : '0)
                                   : DW'(DEAD_BEEF);

    if (TIMEOUT_CYC != 0) begin : g_timeout
        assign w_timeout = (r_cnt == CW'(TIMEOUT_CYC - 1));
    end else begin : g_no_timeout
        assign w_timeout = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_IDLE;
            r_src      <= SRC_IF;
            r_rw       <= RW_READ;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_if_gnt || w_dm_gnt) begin
                        r_state <= ARB_REQ;
                        r_src   <= w_dm_gnt ? SRC_DM : SRC_IF;
                        r_rw    <= cmd_rw(w_dm_gnt, bus.dm_we_i);
                        r_addr  <= w_dm_gnt ? bus.dm_addr_i  : bus.if_addr_i;
                        r_wdata <= w_dm_gnt ? bus.dm_wdata_i : '0;
                        r_be    <= w_dm_gnt ? bus.dm_be_i    : 4'b0000;
                        r_cnt   <= '0;
                    end
                end
                ARB_REQ: begin
                    if (w_done_ok || w_timeout) begin
                        r_state <= ARB_DONE;
                        r_cnt   <= '0;
                        if (r_src == SRC_IF) begin
                            r_if_rdata <= w_resp_data;
                        end else begin
                            r_dm_rdata <= w_resp_data;
                        end
                        if (!w_done_ok) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ARB_DONE: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt_o    = w_if_gnt;
    assign bus.dm_gnt_o    = w_dm_gnt;
    assign bus.if_rvalid_o = (r_state == ARB_DONE) && (r_src == SRC_IF);
    assign bus.dm_rvalid_o = (r_state == ARB_DONE) && (r_src == SRC_DM);
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.dm_rdata_o  = r_dm_rdata;

    assign bus.mem_start_o = (r_state == ARB_REQ);
    assign bus.mem_rw_o    = r_rw;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.mem_be_o    = r_be;

    assign busy_o = (r_state != ARB_IDLE);
    assign err_o  = r_err;

endmodule
`default_nettype wire
